// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter
//
// Shares one UART_TX byte transmitter between two requesters. Every granted
// request goes out as one fixed frame: HDR0, HDR1, ADDR[15:8], ADDR[7:0], DATA.
// Channels are arbitrated round-robin, one frame at a time. A watchdog aborts
// the frame when a byte is not acknowledged by tx_done within TIMEOUT cycles.
//
// Optional feature: define UART_FRAME_CHECKSUM_EN to append a sixth byte,
// CHK = HDR0 ^ HDR1 ^ ADDR[15:8] ^ ADDR[7:0] ^ DATA, after DATA.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   req[1:0]     per-channel request level, held until ack
//   req_addr0/1  channel address, sampled at grant
//   req_data0/1  channel payload, sampled at grant
//   ack[1:0]     one-cycle pulse: request accepted, inputs latched
//   done[1:0]    one-cycle pulse: frame fully transmitted
//   tx_valid     one-cycle pulse to UART_TX i_valid
//   tx_data      byte to UART_TX i_data_in, stable from tx_valid until tx_done
//   tx_done      UART_TX byte-complete pulse
//   busy         high whenever the arbiter is not idle
//   err_timeout  one-cycle pulse on watchdog abort

module uart_frame_arbiter #(
    parameter logic [7:0] HDR0    = 8'hFA,
    parameter logic [7:0] HDR1    = 8'hF1,
    parameter int         TIMEOUT = 1000000,
    parameter int         TO_W    = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] req_addr0,
    input  logic [7:0]  req_data0,
    input  logic [15:0] req_addr1,
    input  logic [7:0]  req_data1,
    output logic [1:0]  ack,
    output logic [1:0]  done,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic        err_timeout
);

`ifdef UART_FRAME_CHECKSUM_EN
    localparam logic [2:0] LAST = 3'd5;
`else
    localparam logic [2:0] LAST = 3'd4;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    state_t          state, state_d;
    logic            rr, rr_d;          // channel granted last; the other wins a tie
    logic            gnt, gnt_d;        // channel owning the in-flight frame
    logic [2:0]      idx, idx_d;
    logic [TO_W-1:0] cnt, cnt_d;
    logic [15:0]     addr, addr_d;
    logic [7:0]      data, data_d;
    logic [1:0]      ack_d, done_d;
    logic            tx_valid_d, err_d;
    logic [7:0]      tx_data_d;
    logic [7:0]      frame_byte;
    logic            grant_ch;

    // A lone requester wins; on a tie the channel not granted last time wins.
    assign grant_ch = (req == 2'b11) ? ~rr : req[1];
    assign busy     = (state != IDLE);

    always_comb begin
        frame_byte = 8'h00;
        case (idx)
            3'd0:    frame_byte = HDR0;
            3'd1:    frame_byte = HDR1;
            3'd2:    frame_byte = addr[15:8];
            3'd3:    frame_byte = addr[7:0];
            3'd4:    frame_byte = data;
`ifdef UART_FRAME_CHECKSUM_EN
            3'd5:    frame_byte = HDR0 ^ HDR1 ^ addr[15:8] ^ addr[7:0] ^ data;
`endif
            default: frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path can leave a value unassigned and infer a latch. Pulses
        // default to 0, everything else holds its registered value.
        state_d    = state;
        rr_d       = rr;
        gnt_d      = gnt;
        idx_d      = idx;
        cnt_d      = cnt;
        addr_d     = addr;
        data_d     = data;
        tx_data_d  = tx_data;
        ack_d      = 2'b00;
        done_d     = 2'b00;
        tx_valid_d = 1'b0;
        err_d      = 1'b0;

        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    ack_d   = grant_ch ? 2'b10 : 2'b01;
                    addr_d  = grant_ch ? req_addr1 : req_addr0;
                    data_d  = grant_ch ? req_data1 : req_data0;
                    rr_d    = grant_ch;
                    gnt_d   = grant_ch;
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_data_d  = frame_byte;
                tx_valid_d = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // tx_done takes priority, so a byte completing on the very
                // cycle the watchdog expires still counts as delivered.
                if (tx_done) begin
                    if (idx == LAST) begin
                        done_d  = gnt ? 2'b10 : 2'b01;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx + 3'd1;
                        state_d = SEND;
                    end
                end else if (cnt == TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above, whatever the order
    // in which the simulator evaluates the statements.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr          <= 1'b1;
            gnt         <= 1'b0;
            idx         <= 3'd0;
            cnt         <= '0;
            addr        <= 16'h0000;
            data        <= 8'h00;
            ack         <= 2'b00;
            done        <= 2'b00;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            rr          <= rr_d;
            gnt         <= gnt_d;
            idx         <= idx_d;
            cnt         <= cnt_d;
            addr        <= addr_d;
            data        <= data_d;
            ack         <= ack_d;
            done        <= done_d;
            tx_valid    <= tx_valid_d;
            tx_data     <= tx_data_d;
            err_timeout <= err_d;
        end
    end

endmodule
